rx_cmd_parser: RTL and testbench
================================

RX_CMD_PARSER -- requirements
Module: rx_cmd_parser

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8: width of received byte and operand fields.
REQ-002 SHALL have parameter ADDR_WIDTH, default 4: register-file address width taken from the address byte.
REQ-003 SHALL have parameter FUN_WIDTH, default 4: ALU function width taken from the function byte.
REQ-004 SHALL have port CLK  input  1: single clock; all state on rising edge.
REQ-005 SHALL have port RST  input  1: asynchronous, active-low reset.
REQ-006 SHALL have port RX_P_DATA  input  DATA_WIDTH: byte from the UART receiver.
REQ-007 SHALL have port RX_D_VLD  input  1: one-cycle pulse, RX_P_DATA valid.
REQ-008 SHALL have ports PAR_ERR, STP_ERR  input  1 each: receiver error flags, sampled with RX_D_VLD.
REQ-009 SHALL have ports CMD_VALID output 1 and CMD_READY input 1: command handshake.
REQ-010 SHALL have port CMD_OP  output  2: 0 = reg write, 1 = reg read, 2 = ALU with operands, 3 = ALU no operands.
REQ-011 SHALL have ports CMD_ADDR (ADDR_WIDTH), CMD_WDATA, CMD_OPA, CMD_OPB (DATA_WIDTH each) and CMD_FUN (FUN_WIDTH), all outputs: command fields.
REQ-012 SHALL have port FRM_ERR  output  1: one-cycle pulse per aborted or dropped byte.
REQ-013 SHALL have port ERR_CNT  output  8: saturating count of FRM_ERR pulses.

Function
REQ-014 SHALL decode the opcode byte in IDLE: 0xAA write (addr, data), 0xBB read (addr), 0xCC ALU (opA, opB, fun), 0xDD ALU-no-operand (fun).
REQ-015 SHALL implement FSM states IDLE, WR_ADDR, WR_DATA, RD_ADDR, ALU_OPA, ALU_OPB, ALU_FUN, ISSUE; advance exactly one state per accepted byte.
REQ-016 SHALL accept a byte only when RX_D_VLD=1 and PAR_ERR=0 and STP_ERR=0.
REQ-017 SHALL, on RX_D_VLD with PAR_ERR or STP_ERR high in any collecting state, discard the byte, pulse FRM_ERR next cycle, and return to IDLE.
REQ-018 SHALL, on an unknown opcode in IDLE, stay in IDLE and pulse FRM_ERR next cycle.
REQ-019 SHALL capture address as RX_P_DATA[ADDR_WIDTH-1:0] and function as RX_P_DATA[FUN_WIDTH-1:0]; upper bits ignored.
REQ-020 SHALL assert CMD_VALID the cycle after the final byte's RX_D_VLD (latency 1) and enter ISSUE.
REQ-021 SHALL hold CMD_VALID and all CMD_* fields stable until the cycle CMD_VALID and CMD_READY are both 1; return to IDLE and deassert CMD_VALID next cycle.
REQ-022 SHALL, on RX_D_VLD in ISSUE (including the handshake cycle), drop the byte and pulse FRM_ERR (overrun).
REQ-023 SHALL leave fields not used by the current opcode at their previous values.
REQ-024 SHALL have no inter-byte timeout; gaps of any length between bytes are legal.
REQ-025 SHALL increment ERR_CNT on every FRM_ERR pulse, saturating at 255, never wrapping.

Reset
REQ-026 SHALL, on RST=0, immediately force state IDLE, CMD_VALID=0, FRM_ERR=0, ERR_CNT=0, CMD_OP=0 and all CMD_* fields 0.
REQ-027 SHALL, on reset mid-command, discard partial command; first byte after release is treated as an opcode.

Structure
REQ-028 SHALL place opcode constants (0xAA/0xBB/0xCC/0xDD), CMD_OP encodings and the state type in shared package rx_cmd_pkg.
REQ-029 SHALL implement the saturating error counter as sub-module rx_err_counter; the rest is a single FSM plus field registers.

Verification
REQ-030 SHALL cover: bytes AA,05,3C with CMD_READY=1 -> one CMD_VALID cycle, CMD_OP=0, CMD_ADDR=5, CMD_WDATA=0x3C.
REQ-031 SHALL cover: bytes CC,12,34,F1, CMD_READY=0 for 10 cycles -> CMD_VALID held, OPA=0x12, OPB=0x34, FUN=1 stable until READY.
REQ-032 SHALL cover: AA,07 then byte with PAR_ERR=1 -> FRM_ERR pulse, ERR_CNT=1, no CMD_VALID; next BB,09 -> CMD_OP=1, CMD_ADDR=9.
REQ-033 SHALL cover: opcode 0x55 -> FRM_ERR pulse, state IDLE; byte during ISSUE -> FRM_ERR, command fields unchanged.
REQ-034 SHALL cover: 260 bad-stop-bit bytes -> ERR_CNT=255; RST low after CC,01 -> all outputs 0, then DD,02 -> CMD_OP=3, CMD_FUN=2.

Source files
------------

// File: rtl/rx_cmd_pkg.sv
// rx_cmd_pkg: shared definitions for the UART command parser.
//   - opcode byte constants recognised in IDLE
//   - CMD_OP encodings presented on the command interface
//   - parser FSM state type
package rx_cmd_pkg;

  localparam logic [7:0] OPC_WR      = 8'hAA;  // reg write : addr, data
  localparam logic [7:0] OPC_RD      = 8'hBB;  // reg read  : addr
  localparam logic [7:0] OPC_ALU     = 8'hCC;  // ALU       : opA, opB, fun
  localparam logic [7:0] OPC_ALU_NOP = 8'hDD;  // ALU       : fun only

  typedef enum logic [1:0] {
    OP_WR      = 2'd0,
    OP_RD      = 2'd1,
    OP_ALU     = 2'd2,
    OP_ALU_NOP = 2'd3
  } cmd_op_e;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_ADDR = 3'd1,
    WR_DATA = 3'd2,
    RD_ADDR = 3'd3,
    ALU_OPA = 3'd4,
    ALU_OPB = 3'd5,
    ALU_FUN = 3'd6,
    ISSUE   = 3'd7
  } state_e;

endpackage

// File: rtl/rx_err_counter.sv
// rx_err_counter: saturating event counter.
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset, clears the count
//   inc   : count one event this cycle
//   cnt   : current count, sticks at all-ones instead of wrapping
module rx_err_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      cnt <= '0;
    else if (inc && (cnt != {CNT_W{1'b1}}))
      cnt <= cnt + CNT_W'(1);
  end

endmodule

// File: rtl/rx_cmd_parser.sv
// rx_cmd_parser: turns a stream of UART bytes into register / ALU commands.
//   CLK, RST          : clock (rising edge) and asynchronous active-low reset
//   RX_P_DATA/RX_D_VLD: received byte and its one-cycle valid strobe
//   PAR_ERR, STP_ERR  : receiver error flags qualifying the current byte
//   CMD_VALID/READY   : command handshake; fields held while VALID && !READY
//   CMD_OP            : 0 write, 1 read, 2 ALU with operands, 3 ALU no operands
//   CMD_ADDR/WDATA/OPA/OPB/FUN : command fields, untouched when unused
//   FRM_ERR           : one-cycle pulse per aborted or dropped byte
//   ERR_CNT           : saturating count of FRM_ERR pulses
module rx_cmd_parser
  import rx_cmd_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int FUN_WIDTH  = 4
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] RX_P_DATA,
  input  logic                  RX_D_VLD,
  input  logic                  PAR_ERR,
  input  logic                  STP_ERR,
  output logic                  CMD_VALID,
  input  logic                  CMD_READY,
  output logic [1:0]            CMD_OP,
  output logic [ADDR_WIDTH-1:0] CMD_ADDR,
  output logic [DATA_WIDTH-1:0] CMD_WDATA,
  output logic [DATA_WIDTH-1:0] CMD_OPA,
  output logic [DATA_WIDTH-1:0] CMD_OPB,
  output logic [FUN_WIDTH-1:0]  CMD_FUN,
  output logic                  FRM_ERR,
  output logic [7:0]            ERR_CNT
);

  state_e  state, state_d;
  cmd_op_e op_q, op_d;
  logic    frm_err_d;
  logic    ld_op, ld_addr, ld_wdata, ld_opa, ld_opb, ld_fun;
  logic    good, bad;

  // A byte is usable only when the receiver reports it clean.
  assign good = RX_D_VLD && !PAR_ERR && !STP_ERR;
  assign bad  = RX_D_VLD && (PAR_ERR || STP_ERR);

  // ------------------------------------------------------------------
  // State register
  // ------------------------------------------------------------------
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state   <= IDLE;
      FRM_ERR <= 1'b0;
    end else begin
      state   <= state_d;
      FRM_ERR <= frm_err_d;
    end
  end

  // ------------------------------------------------------------------
  // Next state, field load enables and error pulse request
  // ------------------------------------------------------------------
  always_comb begin
    state_d   = state;
    op_d      = op_q;
    frm_err_d = 1'b0;
    ld_op     = 1'b0;
    ld_addr   = 1'b0;
    ld_wdata  = 1'b0;
    ld_opa    = 1'b0;
    ld_opb    = 1'b0;
    ld_fun    = 1'b0;

    case (state)
      IDLE: begin
        if (good) begin
          ld_op = 1'b1;
          if (RX_P_DATA == DATA_WIDTH'(OPC_WR)) begin
            op_d    = OP_WR;
            state_d = WR_ADDR;
          end else if (RX_P_DATA == DATA_WIDTH'(OPC_RD)) begin
            op_d    = OP_RD;
            state_d = RD_ADDR;
          end else if (RX_P_DATA == DATA_WIDTH'(OPC_ALU)) begin
            op_d    = OP_ALU;
            state_d = ALU_OPA;
          end else if (RX_P_DATA == DATA_WIDTH'(OPC_ALU_NOP)) begin
            op_d    = OP_ALU_NOP;
            state_d = ALU_FUN;
          end else begin
            // Unknown opcode: the previous CMD_OP stays as it was.
            ld_op     = 1'b0;
            frm_err_d = 1'b1;
          end
        end else if (bad) begin
          frm_err_d = 1'b1;
        end
      end

      WR_ADDR: begin
        if (bad) begin
          frm_err_d = 1'b1;
          state_d   = IDLE;
        end else if (good) begin
          ld_addr = 1'b1;
          state_d = WR_DATA;
        end
      end

      WR_DATA: begin
        if (bad) begin
          frm_err_d = 1'b1;
          state_d   = IDLE;
        end else if (good) begin
          ld_wdata = 1'b1;
          state_d  = ISSUE;
        end
      end

      RD_ADDR: begin
        if (bad) begin
          frm_err_d = 1'b1;
          state_d   = IDLE;
        end else if (good) begin
          ld_addr = 1'b1;
          state_d = ISSUE;
        end
      end

      ALU_OPA: begin
        if (bad) begin
          frm_err_d = 1'b1;
          state_d   = IDLE;
        end else if (good) begin
          ld_opa  = 1'b1;
          state_d = ALU_OPB;
        end
      end

      ALU_OPB: begin
        if (bad) begin
          frm_err_d = 1'b1;
          state_d   = IDLE;
        end else if (good) begin
          ld_opb  = 1'b1;
          state_d = ALU_FUN;
        end
      end

      ALU_FUN: begin
        if (bad) begin
          frm_err_d = 1'b1;
          state_d   = IDLE;
        end else if (good) begin
          ld_fun  = 1'b1;
          state_d = ISSUE;
        end
      end

      ISSUE: begin
        // Any byte arriving while a command is pending is an overrun,
        // clean or not, and never touches the held fields.
        if (RX_D_VLD)
          frm_err_d = 1'b1;
        if (CMD_READY)
          state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  // ------------------------------------------------------------------
  // Command field registers; only the field named by the current byte
  // position is loaded, everything else keeps its last value.
  // ------------------------------------------------------------------
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      op_q      <= OP_WR;
      CMD_ADDR  <= '0;
      CMD_WDATA <= '0;
      CMD_OPA   <= '0;
      CMD_OPB   <= '0;
      CMD_FUN   <= '0;
    end else begin
      if (ld_op)    op_q      <= op_d;
      if (ld_addr)  CMD_ADDR  <= RX_P_DATA[ADDR_WIDTH-1:0];
      if (ld_wdata) CMD_WDATA <= RX_P_DATA;
      if (ld_opa)   CMD_OPA   <= RX_P_DATA;
      if (ld_opb)   CMD_OPB   <= RX_P_DATA;
      if (ld_fun)   CMD_FUN   <= RX_P_DATA[FUN_WIDTH-1:0];
    end
  end

  assign CMD_OP    = op_q;
  assign CMD_VALID = (state == ISSUE);

  rx_err_counter #(
    .CNT_W (8)
  ) u_err_cnt (
    .clk   (CLK),
    .rst_n (RST),
    .inc   (FRM_ERR),
    .cnt   (ERR_CNT)
  );

endmodule

// File: tb/tb_rx_cmd_parser.sv
// tb_rx_cmd_parser: directed scenarios plus randomized command traffic,
// checked against a command-level reference model of the parser.
module tb_rx_cmd_parser;

  logic       CLK = 1'b0;
  logic       RST;
  logic [7:0] RX_P_DATA;
  logic       RX_D_VLD, PAR_ERR, STP_ERR;
  logic       CMD_VALID, CMD_READY;
  logic [1:0] CMD_OP;
  logic [3:0] CMD_ADDR, CMD_FUN;
  logic [7:0] CMD_WDATA, CMD_OPA, CMD_OPB;
  logic       FRM_ERR;
  logic [7:0] ERR_CNT;

  int errors = 0;
  int checks = 0;

  // Reference model: what the command interface should show.
  typedef struct {
    logic [1:0] op;
    logic [3:0] addr;
    logic [7:0] wdata;
    logic [7:0] opa;
    logic [7:0] opb;
    logic [3:0] fun;
  } cmd_t;

  cmd_t m;
  int   err_events;

  rx_cmd_parser #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .FUN_WIDTH(4)) dut (
    .CLK(CLK), .RST(RST),
    .RX_P_DATA(RX_P_DATA), .RX_D_VLD(RX_D_VLD),
    .PAR_ERR(PAR_ERR), .STP_ERR(STP_ERR),
    .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY),
    .CMD_OP(CMD_OP), .CMD_ADDR(CMD_ADDR), .CMD_WDATA(CMD_WDATA),
    .CMD_OPA(CMD_OPA), .CMD_OPB(CMD_OPB), .CMD_FUN(CMD_FUN),
    .FRM_ERR(FRM_ERR), .ERR_CNT(ERR_CNT)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int sat(input int n);
    return (n > 255) ? 255 : n;
  endfunction

  // Called at a negedge; presents one byte for one cycle and returns at the
  // next negedge, where the consequences of that byte are visible.
  task automatic send_byte(input logic [7:0] d, input logic p = 1'b0, input logic s = 1'b0);
    RX_P_DATA = d; PAR_ERR = p; STP_ERR = s; RX_D_VLD = 1'b1;
    @(negedge CLK);
    RX_D_VLD = 1'b0; PAR_ERR = 1'b0; STP_ERR = 1'b0;
  endtask

  task automatic check_fields(input string tag);
    check({tag, ".op"},    32'(CMD_OP),    32'(m.op));
    check({tag, ".addr"},  32'(CMD_ADDR),  32'(m.addr));
    check({tag, ".wdata"}, 32'(CMD_WDATA), 32'(m.wdata));
    check({tag, ".opa"},   32'(CMD_OPA),   32'(m.opa));
    check({tag, ".opb"},   32'(CMD_OPB),   32'(m.opb));
    check({tag, ".fun"},   32'(CMD_FUN),   32'(m.fun));
  endtask

  // Complete a pending command after 'hold' stall cycles.
  task automatic finish_cmd(input string tag, input int hold);
    for (int i = 0; i < hold; i++) begin
      @(negedge CLK);
      check({tag, ".held_valid"}, 32'(CMD_VALID), 32'd1);
    end
    CMD_READY = 1'b1;
    @(negedge CLK);
    CMD_READY = 1'b0;
    check({tag, ".valid_drop"}, 32'(CMD_VALID), 32'd0);
  endtask

  initial begin
    logic [7:0] a, b, c, x;
    int         k, hold;

    RST = 1'b0; RX_P_DATA = '0; RX_D_VLD = 1'b0; PAR_ERR = 1'b0; STP_ERR = 1'b0;
    CMD_READY = 1'b0;
    m = '{op: 2'd0, addr: 4'd0, wdata: 8'd0, opa: 8'd0, opb: 8'd0, fun: 4'd0};
    err_events = 0;

    // Reset state
    repeat (2) @(negedge CLK);
    check("rst.valid", 32'(CMD_VALID), 32'd0);
    check("rst.frm",   32'(FRM_ERR),   32'd0);
    check("rst.cnt",   32'(ERR_CNT),   32'd0);
    check_fields("rst");
    RST = 1'b1;
    @(negedge CLK);

    // Write with READY already high: exactly one VALID cycle
    CMD_READY = 1'b1;
    send_byte(8'hAA); send_byte(8'h05); send_byte(8'h3C);
    m.op = 2'd0; m.addr = 4'h5; m.wdata = 8'h3C;
    check("wr.valid", 32'(CMD_VALID), 32'd1);
    check_fields("wr");
    @(negedge CLK);
    check("wr.one_cycle", 32'(CMD_VALID), 32'd0);
    CMD_READY = 1'b0;

    // ALU command stalled for 10 cycles
    send_byte(8'hCC); send_byte(8'h12); send_byte(8'h34); send_byte(8'hF1);
    m.op = 2'd2; m.opa = 8'h12; m.opb = 8'h34; m.fun = 4'h1;
    check("alu.valid", 32'(CMD_VALID), 32'd1);
    for (int i = 0; i < 10; i++) begin
      @(negedge CLK);
      check("alu.held", 32'(CMD_VALID), 32'd1);
      check_fields("alu.stall");
    end
    finish_cmd("alu", 0);

    // Parity error aborts a write
    send_byte(8'hAA); send_byte(8'h07); send_byte(8'h99, 1'b1, 1'b0);
    err_events++;
    m.addr = 4'h7;   // address byte was accepted before the abort
    check("par.frm",   32'(FRM_ERR),   32'd1);
    check("par.valid", 32'(CMD_VALID), 32'd0);
    @(negedge CLK);
    check("par.frm_pulse", 32'(FRM_ERR), 32'd0);
    check("par.cnt",   32'(ERR_CNT),   32'(err_events));
    check("par.novalid", 32'(CMD_VALID), 32'd0);
    send_byte(8'hBB); send_byte(8'h09);
    m.op = 2'd1; m.addr = 4'h9;
    check("rd.valid", 32'(CMD_VALID), 32'd1);
    check_fields("rd");
    finish_cmd("rd", 1);

    // Unknown opcode stays in IDLE
    send_byte(8'h55);
    err_events++;
    check("unk.frm", 32'(FRM_ERR), 32'd1);
    check("unk.valid", 32'(CMD_VALID), 32'd0);
    send_byte(8'hBB); send_byte(8'h03);
    m.op = 2'd1; m.addr = 4'h3;
    check("unk.next_valid", 32'(CMD_VALID), 32'd1);
    check_fields("unk.next");
    finish_cmd("unk.next", 0);

    // Overrun while a command is pending
    send_byte(8'hAA); send_byte(8'h0A); send_byte(8'h55);
    m.op = 2'd0; m.addr = 4'hA; m.wdata = 8'h55;
    send_byte(8'h77);
    err_events++;
    check("ovr.frm",   32'(FRM_ERR),   32'd1);
    check("ovr.valid", 32'(CMD_VALID), 32'd1);
    check_fields("ovr");
    // Overrun on the handshake cycle itself
    CMD_READY = 1'b1;
    send_byte(8'hBB);
    CMD_READY = 1'b0;
    err_events++;
    check("ovr_hs.frm",   32'(FRM_ERR),   32'd1);
    check("ovr_hs.valid", 32'(CMD_VALID), 32'd0);
    check_fields("ovr_hs");
    @(negedge CLK);
    check("ovr.cnt", 32'(ERR_CNT), 32'(err_events));

    // Randomized traffic
    for (int n = 0; n < 40; n++) begin
      repeat ($urandom_range(0, 3)) @(negedge CLK);
      k = $urandom_range(0, 5);
      a = 8'($urandom); b = 8'($urandom); c = 8'($urandom);
      case (k)
        0: begin
          send_byte(8'hAA); send_byte(a); send_byte(b);
          m.op = 2'd0; m.addr = a[3:0]; m.wdata = b;
        end
        1: begin
          send_byte(8'hBB); send_byte(a);
          m.op = 2'd1; m.addr = a[3:0];
        end
        2: begin
          send_byte(8'hCC); send_byte(a); send_byte(b); send_byte(c);
          m.op = 2'd2; m.opa = a; m.opb = b; m.fun = c[3:0];
        end
        3: begin
          send_byte(8'hDD); send_byte(c);
          m.op = 2'd3; m.fun = c[3:0];
        end
        4: begin
          x = 8'($urandom);
          if (x == 8'hAA || x == 8'hBB || x == 8'hCC || x == 8'hDD) x = 8'h00;
          send_byte(x);
          err_events++;
        end
        default: begin
          send_byte(a, 1'($urandom), 1'b1);
          err_events++;
        end
      endcase
      if (k < 4) begin
        check("rnd.valid", 32'(CMD_VALID), 32'd1);
        check_fields("rnd");
        hold = $urandom_range(0, 3);
        finish_cmd("rnd", hold);
      end else begin
        check("rnd.frm", 32'(FRM_ERR), 32'd1);
        check("rnd.novalid", 32'(CMD_VALID), 32'd0);
      end
    end
    @(negedge CLK);
    check("rnd.cnt", 32'(ERR_CNT), 32'(sat(err_events)));

    // Counter saturation
    for (int i = 0; i < 260; i++) send_byte(8'($urandom), 1'b0, 1'b1);
    err_events += 260;
    @(negedge CLK);
    check("sat.cnt", 32'(ERR_CNT), 32'(sat(err_events)));
    check_fields("sat");

    // Reset in the middle of a command
    send_byte(8'hCC); send_byte(8'h01);
    RST = 1'b0;
    #1;
    check("mrst.valid", 32'(CMD_VALID), 32'd0);
    check("mrst.frm",   32'(FRM_ERR),   32'd0);
    check("mrst.cnt",   32'(ERR_CNT),   32'd0);
    m = '{op: 2'd0, addr: 4'd0, wdata: 8'd0, opa: 8'd0, opb: 8'd0, fun: 4'd0};
    check_fields("mrst");
    @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    send_byte(8'hDD); send_byte(8'h02);
    m.op = 2'd3; m.fun = 4'h2;
    check("dd.valid", 32'(CMD_VALID), 32'd1);
    check_fields("dd");
    finish_cmd("dd", 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
